// File: rtl/css_mcu0_el2_dccm_init_seq_if.sv
// DCCM bank port bundle: one clock enable, write enable, row address, write
// data/ECC per bank going down, read data/ECC per bank coming back.
//   master : drives the request (clken/wren/addr/wr_data/wr_ecc), takes read data
//   slave  : takes the request, drives read data (rd_data/rd_ecc)
interface css_mcu0_el2_dccm_init_seq_if #(
  parameter int NUM_BANKS = 4,
  parameter int ROW_W     = 10,
  parameter int DATA_W    = 32,
  parameter int ECC_W     = 7
);
  logic [NUM_BANKS-1:0]             clken;
  logic [NUM_BANKS-1:0]             wren;
  logic [NUM_BANKS-1:0][ROW_W-1:0]  addr;
  logic [NUM_BANKS-1:0][DATA_W-1:0] wr_data;
  logic [NUM_BANKS-1:0][ECC_W-1:0]  wr_ecc;
  logic [NUM_BANKS-1:0][DATA_W-1:0] rd_data;
  logic [NUM_BANKS-1:0][ECC_W-1:0]  rd_ecc;

  modport master (output clken, wren, addr, wr_data, wr_ecc, input rd_data, rd_ecc);
  modport slave  (input clken, wren, addr, wr_data, wr_ecc, output rd_data, rd_ecc);
endinterface

// File: rtl/css_mcu0_el2_dccm_init_seq.sv
// DCCM initialization sequencer. Sits between the core DCCM port and the SRAM
// banks. After reset (AUTO_INIT) or on zeroize_req_i it writes zero data plus
// INIT_ECC to every row of every bank in parallel, one row per cycle, while the
// core is held off; afterwards core traffic passes straight through.
// Ports:
//   clk, rst_l     : clock, synchronous active-low reset
//   zeroize_req_i  : one-cycle pulse, starts a sweep from READY (or IDLE)
//   core           : core-side bank port (slave)
//   sram           : SRAM-side bank port (master)
//   init_busy_o    : sweep in progress
//   init_done_o    : a sweep has completed and none is running
//   drop_cnt_o     : saturating count of core accesses dropped while not READY
module css_mcu0_el2_dccm_init_seq #(
  parameter int              NUM_BANKS = 4,
  parameter int              ROW_W     = 10,
  parameter int              DATA_W    = 32,
  parameter int              ECC_W     = 7,
  parameter logic [ECC_W-1:0] INIT_ECC = '0,
  parameter bit              AUTO_INIT = 1'b1
) (
  input  logic clk,
  input  logic rst_l,
  input  logic zeroize_req_i,
  css_mcu0_el2_dccm_init_seq_if.slave  core,
  css_mcu0_el2_dccm_init_seq_if.master sram,
  output logic       init_busy_o,
  output logic       init_done_o,
  output logic [7:0] drop_cnt_o
);

  typedef enum logic [1:0] {IDLE, SWEEP, READY} state_e;

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [7:0]       drop_q, drop_d;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q <= IDLE;
      row_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    drop_d  = drop_q;
    // Anything the core issues outside READY never reaches the SRAM.
    if (state_q != READY && |core.clken && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;
    unique case (state_q)
      IDLE: begin
        if (AUTO_INIT || zeroize_req_i) begin
          state_d = SWEEP;
          row_d   = '0;
        end
      end
      SWEEP: begin
        // zeroize_req_i is deliberately ignored here: no restart mid-sweep.
        row_d = row_q + 1'b1;
        if (row_q == '1) begin
          state_d = READY;
          row_d   = '0;
        end
      end
      READY: begin
        if (zeroize_req_i) begin
          state_d = SWEEP;
          row_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        row_d   = '0;
      end
    endcase
  end

  logic sweep, ready;
  assign sweep = (state_q == SWEEP);
  assign ready = (state_q == READY);

  logic [NUM_BANKS-1:0]             clken_m, wren_m;
  logic [NUM_BANKS-1:0][ROW_W-1:0]  addr_m;
  logic [NUM_BANKS-1:0][DATA_W-1:0] wdata_m;
  logic [NUM_BANKS-1:0][ECC_W-1:0]  wecc_m;

  // Per-bank SRAM mux: sweep pattern, core passthrough, or quiet (IDLE).
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign clken_m[b] = sweep | (ready & core.clken[b]);
    assign wren_m[b]  = sweep | (ready & core.wren[b]);
    assign addr_m[b]  = sweep ? row_q    : (ready ? core.addr[b]   : '0);
    assign wdata_m[b] = ready ? core.wr_data[b] : '0;
    assign wecc_m[b]  = sweep ? INIT_ECC : (ready ? core.wr_ecc[b] : '0);
  end

  assign sram.clken   = clken_m;
  assign sram.wren    = wren_m;
  assign sram.addr    = addr_m;
  assign sram.wr_data = wdata_m;
  assign sram.wr_ecc  = wecc_m;

  // Read return is unconditional; latency is whatever the SRAM gives.
  assign core.rd_data = sram.rd_data;
  assign core.rd_ecc  = sram.rd_ecc;

  assign init_busy_o = sweep;
  assign init_done_o = ready;
  assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_css_mcu0_el2_dccm_init_seq.sv
module tb_css_mcu0_el2_dccm_init_seq;
  localparam int NB = 4, RW = 4, DW = 32, EW = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, zr_a, zr_b;
  logic busy_a, done_a, busy_b, done_b;
  logic [7:0] drop_a, drop_b;

  css_mcu0_el2_dccm_init_seq_if #(.NUM_BANKS(NB), .ROW_W(RW), .DATA_W(DW), .ECC_W(EW)) core_a ();
  css_mcu0_el2_dccm_init_seq_if #(.NUM_BANKS(NB), .ROW_W(RW), .DATA_W(DW), .ECC_W(EW)) sram_a ();
  css_mcu0_el2_dccm_init_seq_if #(.NUM_BANKS(NB), .ROW_W(RW), .DATA_W(DW), .ECC_W(EW)) core_b ();
  css_mcu0_el2_dccm_init_seq_if #(.NUM_BANKS(NB), .ROW_W(RW), .DATA_W(DW), .ECC_W(EW)) sram_b ();

  css_mcu0_el2_dccm_init_seq #(.NUM_BANKS(NB), .ROW_W(RW), .DATA_W(DW), .ECC_W(EW),
    .INIT_ECC(7'h00), .AUTO_INIT(1'b1)) dut_a (
    .clk(clk), .rst_l(rst_a), .zeroize_req_i(zr_a), .core(core_a.slave), .sram(sram_a.master),
    .init_busy_o(busy_a), .init_done_o(done_a), .drop_cnt_o(drop_a));

  css_mcu0_el2_dccm_init_seq #(.NUM_BANKS(NB), .ROW_W(RW), .DATA_W(DW), .ECC_W(EW),
    .INIT_ECC(7'h13), .AUTO_INIT(1'b0)) dut_b (
    .clk(clk), .rst_l(rst_b), .zeroize_req_i(zr_b), .core(core_b.slave), .sram(sram_b.master),
    .init_busy_o(busy_b), .init_done_o(done_b), .drop_cnt_o(drop_b));

  int checks = 0, errs = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_core_a();
    core_a.clken = '0; core_a.wren = '0; core_a.addr = '0;
    core_a.wr_data = '0; core_a.wr_ecc = '0;
  endtask

  // One sweep cycle of dut_a: all banks written, row k, zero data/ECC.
  task automatic chk_sweep_a(input int k, input string tag);
    logic [15:0] ea;
    ea = {4{k[3:0]}};
    #1;
    chk($sformatf("%s_row%0d", tag, k),
        256'({sram_a.clken, sram_a.wren, sram_a.addr, sram_a.wr_data, sram_a.wr_ecc, busy_a, done_a}),
        256'({4'hF, 4'hF, ea, 128'h0, 28'h0, 1'b1, 1'b0}));
  endtask

  typedef struct {
    logic [3:0] clken, wren; logic [15:0] addr; logic [127:0] wdata; logic [27:0] wecc;
    logic [127:0] sdout; logic [27:0] secc;
    logic [3:0] e_clken, e_wren; logic [15:0] e_addr; logic [127:0] e_wdata; logic [27:0] e_wecc;
    logic [127:0] e_dout; logic [27:0] e_ecc;
  } vec_t;
  vec_t tbl[4];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    // READY passthrough vectors
    tbl[0] = '{4'h4, 4'h4, 16'h0500, {32'h0, 32'hDEADBEEF, 64'h0}, {7'h0, 7'h2C, 14'h0}, 128'h0, 28'h0,
               4'h4, 4'h4, 16'h0500, {32'h0, 32'hDEADBEEF, 64'h0}, {7'h0, 7'h2C, 14'h0}, 128'h0, 28'h0};
    tbl[1] = '{4'h4, 4'h0, 16'h0500, 128'h0, 28'h0, {32'h0, 32'hDEADBEEF, 64'h0}, {7'h0, 7'h2C, 14'h0},
               4'h4, 4'h0, 16'h0500, 128'h0, 28'h0, {32'h0, 32'hDEADBEEF, 64'h0}, {7'h0, 7'h2C, 14'h0}};
    tbl[2] = '{4'hF, 4'hA, 16'hF3C1, 128'h11112222_33334444_55556666_77778888, 28'h5A5A5A5,
               128'h01234567_89ABCDEF_FEDCBA98_76543210, 28'h1234567,
               4'hF, 4'hA, 16'hF3C1, 128'h11112222_33334444_55556666_77778888, 28'h5A5A5A5,
               128'h01234567_89ABCDEF_FEDCBA98_76543210, 28'h1234567};
    tbl[3] = '{4'h0, 4'h0, 16'h0000, 128'h0, 28'h0, 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000, 28'hFFFFFFF,
               4'h0, 4'h0, 16'h0000, 128'h0, 28'h0, 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000, 28'hFFFFFFF};

    rst_a = 1'b0; rst_b = 1'b0; zr_a = 1'b0; zr_b = 1'b0;
    idle_core_a();
    core_b.clken = '0; core_b.wren = '0; core_b.addr = '0; core_b.wr_data = '0; core_b.wr_ecc = '0;
    sram_a.rd_data = '0; sram_a.rd_ecc = '0; sram_b.rd_data = '0; sram_b.rd_ecc = '0;

    // Reset state; core activity during reset is not counted.
    core_a.clken = 4'h3;
    repeat (3) step();
    chk("reset_a", 256'({busy_a, done_a, drop_a, sram_a.clken, sram_a.wren}), 256'(0));
    idle_core_a();

    // Auto sweep after release, with 3 core accesses dropped mid-sweep.
    rst_a = 1'b1;
    step();
    busy_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 3) begin
        core_a.clken = 4'h1; core_a.wren = 4'h1; core_a.addr = 16'h0009;
        core_a.wr_data = 128'hAAAA; core_a.wr_ecc = 28'h7F;
      end
      if (k == 6) idle_core_a();
      chk_sweep_a(k, "auto");
      if (busy_a) busy_cnt++;
      step();
    end
    chk("auto_done", 256'({busy_a, done_a}), 256'(2'b01));
    chk("busy_cycles", 256'(busy_cnt), 256'(16));
    chk("drop3", 256'(drop_a), 256'(8'd3));

    // READY passthrough table
    for (int i = 0; i < 4; i++) begin
      core_a.clken = tbl[i].clken; core_a.wren = tbl[i].wren; core_a.addr = tbl[i].addr;
      core_a.wr_data = tbl[i].wdata; core_a.wr_ecc = tbl[i].wecc;
      sram_a.rd_data = tbl[i].sdout; sram_a.rd_ecc = tbl[i].secc;
      #1;
      chk($sformatf("pt_req%0d", i),
          256'({sram_a.clken, sram_a.wren, sram_a.addr, sram_a.wr_data, sram_a.wr_ecc}),
          256'({tbl[i].e_clken, tbl[i].e_wren, tbl[i].e_addr, tbl[i].e_wdata, tbl[i].e_wecc}));
      chk($sformatf("pt_rd%0d", i), 256'({core_a.rd_data, core_a.rd_ecc}),
          256'({tbl[i].e_dout, tbl[i].e_ecc}));
      step();
    end
    idle_core_a();
    sram_a.rd_data = '0; sram_a.rd_ecc = '0;
    chk("ready_drop", 256'(drop_a), 256'(8'd3));

    // zeroize in READY, second zeroize mid-sweep is ignored
    zr_a = 1'b1;
    step();
    zr_a = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 7) zr_a = 1'b1;
      if (k == 8) zr_a = 1'b0;
      chk_sweep_a(k, "rez");
      step();
    end
    chk("rez_done", 256'({busy_a, done_a}), 256'(2'b01));

    // drop_cnt saturation: core held active across 19 sweeps
    core_a.clken = 4'h1;
    for (int s = 0; s < 19; s++) begin
      zr_a = 1'b1;
      step();
      zr_a = 1'b0;
      repeat (16) step();
      if (s == 0)  chk("drop19", 256'(drop_a), 256'(8'd19));
      if (s == 14) chk("drop243", 256'(drop_a), 256'(8'd243));
    end
    chk("drop_sat", 256'({done_a, drop_a}), 256'({1'b1, 8'hFF}));
    idle_core_a();

    // Reset at row 7, then full restart from row 0
    zr_a = 1'b1;
    step();
    zr_a = 1'b0;
    repeat (7) step();
    chk_sweep_a(7, "mid");
    rst_a = 1'b0;
    step();
    chk("mid_reset",
        256'({sram_a.clken, sram_a.wren, sram_a.addr, sram_a.wr_data, sram_a.wr_ecc,
              busy_a, done_a, drop_a, core_a.rd_data}), 256'(0));
    rst_a = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
      chk_sweep_a(k, "post");
      step();
    end
    chk("post_done", 256'({busy_a, done_a}), 256'(2'b01));

    // AUTO_INIT=0 instance: waits in IDLE until zeroize
    rst_b = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("b_idle%0d", c), 256'({sram_b.clken, sram_b.wren, busy_b, done_b}), 256'(0));
    end
    zr_b = 1'b1;
    step();
    zr_b = 1'b0;
    for (int k = 0; k < 16; k++) begin
      logic [15:0] ea;
      ea = {4{k[3:0]}};
      #1;
      chk($sformatf("b_row%0d", k),
          256'({sram_b.clken, sram_b.wren, sram_b.addr, sram_b.wr_data, sram_b.wr_ecc, busy_b, done_b}),
          256'({4'hF, 4'hF, ea, 128'h0, {4{7'h13}}, 1'b1, 1'b0}));
      step();
    end
    chk("b_done", 256'({busy_b, done_b, drop_b}), 256'({1'b0, 1'b1, 8'd0}));

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule
